bldc_commutation_gate_driver: RTL and testbench
===============================================

// Module: bldc_commutation_gate_driver
// PURPOSE
//  Six-step BLDC commutation stage for the Tang Nano 9K driver. Upstream of the gate pins
//  and debug probes: it turns rotor step plus duty level into the PWM duty signal and the
//  HIN_R/S/T and _LIN_R/S/T gate outputs. Per-leg dead time blocks high/low shoot-through.
// PARAMETERS
//  PWM_W        8   width of the PWM counter and duty_level; period = 2**PWM_W-1 clocks
//  DEAD_CYCLES  8   minimum clocks a leg is fully off before its opposite switch turns on (>=1)
// PORTS
//  clk           in   1        system clock; all logic on the rising edge
//  rst_n         in   1        asynchronous active-low reset
//  enable        in   1        1 = drive; 0 = all legs off (no dead time needed to turn off)
//  rotate_state  in   3        commutation step 0..5; 6 and 7 are invalid
//  duty_level    in   PWM_W    high-side on-time in clocks per PWM period
//  brake         in   1        present only with COMM_BRAKE_EN
//  duty          out  1        registered PWM gate, also routed to debug probe
//  HIN_R/S/T     out  1 each   high-side gate, active high
//  _LIN_R/S/T    out  1 each   low-side gate, active low (1 = off)
//  state_fault   out  1        sticky: set on an invalid rotate_state, cleared only by reset
// BEHAVIOUR
//  - Reset: duty=0, HIN_*=0, _LIN_*=1, state_fault=0, PWM count=0, leg memory=OFF,
//    dead counters saturated. Reset mid-operation turns every gate off immediately.
//  - PWM: cnt counts 0..2**PWM_W-2, then wraps to 0.
//    - duty_level is latched into duty_q only when cnt==0, so a period is never glitched.
//    - pwm_on = (cnt < duty_q).
//    - duty_level=0 gives always off; duty_level=2**PWM_W-1 gives always on.
//    - duty is the registered pwm_on.
//  - rotate_state is registered once (rs_q). The table applied to rs_q gives {high leg PWM,
//    low leg on}. Every leg not named is OFF.
//    - 0: R+ S-
//    - 1: R+ T-
//    - 2: S+ T-
//    - 3: S+ R-
//    - 4: T+ R-
//    - 5: T+ S-
//    - The high leg wants HIGH only while pwm_on; otherwise that leg wants OFF.
//  - rs_q of 6 or 7: every leg wants OFF and state_fault is set.
//  - enable=0: every leg wants OFF. This overrides the table, not the fault flag.
//  - Per-leg FSM, one each for R, S and T. States: OFF, HI, LO.
//    - In OFF a dead counter counts up each clock and saturates at DEAD_CYCLES.
//    - last_side records the last on-state, HI or LO.
//  - Transitions:
//    - want differs from current on-state: go to OFF in the same clock, counter=0.
//    - OFF -> same side as last_side: allowed immediately. PWM re-turn-on adds no delay.
//    - OFF -> opposite side of last_side: only when counter >= DEAD_CYCLES.
//    - OFF -> HI -> OFF -> LO therefore spends >= DEAD_CYCLES clocks fully off.
//  - Gate outputs are registered from the FSM state: HIN_x = (state==HI), _LIN_x = ~(state==LO).
//    HIN_x and ~_LIN_x are never 1 in the same cycle. This invariant is mandatory.
//  - Latency:
//    - rotate_state change to first gate turn-off: 2 clocks.
//    - turn-on of the opposite side: 2 + DEAD_CYCLES clocks.
//  - Simultaneous step change and PWM edge: the table decides. Turn-off always wins over turn-on.
// CONFIGURATION
//  COMM_BRAKE_EN defined:
//    - Adds the brake port.
//    - brake=1 (with enable=1) makes every leg want LO, using dead time as normal.
//    - Priority: brake beats the table; invalid state beats brake.
//    - duty continues to run.
//  COMM_BRAKE_EN undefined: the brake port and its logic are absent; behaviour is otherwise identical.
// TESTING
//  1 Reset: hold rst_n=0, toggle clk -> HIN_*=0, _LIN_*=1, duty=0, state_fault=0; the async
//    assert mid-PWM drops the gates without a clock edge.
//  2 PWM: duty_level=64, rotate_state=0 -> HIN_R high for 64 of every 255 clocks, _LIN_S=0
//    continuously; T leg off; a duty_level change mid-period takes effect at the next cnt==0.
//  3 Dead time: step 0->3 (R goes HI to LO) -> HIN_R=0 then _LIN_R stays 1 for >=8 clocks
//    before going 0; the assertion HIN_x & ~_LIN_x never fires across a full 0..5 sweep.
//  4 Extremes: duty_level=0 -> HIN_* always 0; duty_level=255 -> HIN_R constant 1 with no
//    dead-time gaps inside step 0.
//  5 Faults/enable: rotate_state=7 -> all off, state_fault=1 and still 1 after returning to 2;
//    enable=0 -> all off within 1 clock.
//  6 COMM_BRAKE_EN: brake=1 during step 1 -> all _LIN_* go 0, R only after 8 off clocks;
//    rebuild without the macro -> port absent and tests 1-5 pass.

Source files
------------

// File: rtl/bldc_commutation_gate_driver.sv
// bldc_commutation_gate_driver
// Six-step BLDC commutation stage: PWM generator, commutation table and one
// dead-time protected OFF/HI/LO state machine per motor leg (R, S, T).
// Optional feature macro: COMM_BRAKE_EN adds the brake input. When brake is set,
// every leg is driven low-side on.
// The high-side gates are active high. The low-side gates are active low.

module bldc_commutation_gate_driver #(
    parameter int PWM_W       = 8,
    parameter int DEAD_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [2:0]       rotate_state,
    input  logic [PWM_W-1:0] duty_level,
`ifdef COMM_BRAKE_EN
    input  logic             brake,
`endif
    output logic             duty,
    output logic             HIN_R,
    output logic             HIN_S,
    output logic             HIN_T,
    output logic             _LIN_R,
    output logic             _LIN_S,
    output logic             _LIN_T,
    output logic             state_fault
);

    localparam int DW = $clog2(DEAD_CYCLES + 1);

    // The last count value before wrap is 2**PWM_W-2, so the period is 2**PWM_W-1 clocks.
    localparam logic [PWM_W-1:0] CNT_LAST = {{(PWM_W-1){1'b1}}, 1'b0};

    // The dead counter saturates at DEAD_CYCLES. An opposite-side turn-on is allowed
    // once the current clock completes DEAD_CYCLES fully-off clocks.
    localparam logic [DW-1:0] DEAD_SAT  = DW'(DEAD_CYCLES);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

    localparam int LEG_R = 0;
    localparam int LEG_S = 1;
    localparam int LEG_T = 2;

    typedef enum logic [1:0] {
        LEG_OFF = 2'd0,
        LEG_HI  = 2'd1,
        LEG_LO  = 2'd2
    } leg_state_t;

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_q;
    logic             pwm_on;

    logic [2:0]       rs_q;
    logic             rs_valid;

    leg_state_t       high_want;
    leg_state_t       tbl_want [3];
    leg_state_t       leg_want [3];

    leg_state_t       leg_q    [3];
    leg_state_t       leg_d    [3];
    leg_state_t       last_q   [3];
    leg_state_t       last_d   [3];
    logic [DW-1:0]    dead_q   [3];
    logic [DW-1:0]    dead_d   [3];

    logic [2:0]       hin_q;
    logic [2:0]       lin_n_q;

    assign pwm_on   = (cnt < duty_q);
    assign rs_valid = (rs_q <= 3'd5);

    // PWM counter; duty_level is sampled only at the period start so a period never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            duty_q <= '0;
            duty   <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == '0) begin
                duty_q <= duty_level;
            end
            duty <= pwm_on;
        end
    end

    // Register the rotor step. The fault flag stays set on an invalid step until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q        <= 3'd0;
            state_fault <= 1'b0;
        end else begin
            rs_q <= rotate_state;
            if (!rs_valid) begin
                state_fault <= 1'b1;
            end
        end
    end

    // Commutation table: each step names one leg for the high side (PWM-gated) and one for the low side.
    always_comb begin
        high_want = pwm_on ? LEG_HI : LEG_OFF;
        for (int i = 0; i < 3; i++) begin
            tbl_want[i] = LEG_OFF;
        end
        case (rs_q)
            3'd0: begin
                tbl_want[LEG_R] = high_want;
                tbl_want[LEG_S] = LEG_LO;
            end
            3'd1: begin
                tbl_want[LEG_R] = high_want;
                tbl_want[LEG_T] = LEG_LO;
            end
            3'd2: begin
                tbl_want[LEG_S] = high_want;
                tbl_want[LEG_T] = LEG_LO;
            end
            3'd3: begin
                tbl_want[LEG_S] = high_want;
                tbl_want[LEG_R] = LEG_LO;
            end
            3'd4: begin
                tbl_want[LEG_T] = high_want;
                tbl_want[LEG_R] = LEG_LO;
            end
            3'd5: begin
                tbl_want[LEG_T] = high_want;
                tbl_want[LEG_S] = LEG_LO;
            end
            default: begin
            end
        endcase
    end

    // Final per-leg request. Priority, highest first: disabled or invalid step, then brake, then the table.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            leg_want[i] = LEG_OFF;
        end
        if (enable && rs_valid) begin
            for (int i = 0; i < 3; i++) begin
                leg_want[i] = tbl_want[i];
            end
`ifdef COMM_BRAKE_EN
            if (brake) begin
                for (int i = 0; i < 3; i++) begin
                    leg_want[i] = LEG_LO;
                end
            end
`endif
        end
    end

    // Leg FSM next state: any change leaves via OFF, and a side swap waits out the dead time.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            leg_d[i]  = leg_q[i];
            last_d[i] = last_q[i];
            dead_d[i] = dead_q[i];
            case (leg_q[i])
                LEG_HI, LEG_LO: begin
                    if (leg_want[i] != leg_q[i]) begin
                        leg_d[i]  = LEG_OFF;
                        dead_d[i] = '0;
                    end
                end
                default: begin
                    if (dead_q[i] != DEAD_SAT) begin
                        dead_d[i] = dead_q[i] + 1'b1;
                    end
                    if ((leg_want[i] != LEG_OFF) &&
                        ((leg_want[i] == last_q[i]) ||
                         (last_q[i] == LEG_OFF) ||
                         (dead_q[i] >= DEAD_LAST))) begin
                        leg_d[i]  = leg_want[i];
                        last_d[i] = leg_want[i];
                    end
                end
            endcase
        end
    end

    // Leg FSM state, side memory and dead counters; reset leaves the counters saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                leg_q[i]  <= LEG_OFF;
                last_q[i] <= LEG_OFF;
                dead_q[i] <= DEAD_SAT;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                leg_q[i]  <= leg_d[i];
                last_q[i] <= last_d[i];
                dead_q[i] <= dead_d[i];
            end
        end
    end

    // Gate registers load from the same next state as the FSM, so each pin is a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hin_q   <= 3'b000;
            lin_n_q <= 3'b111;
        end else begin
            for (int i = 0; i < 3; i++) begin
                hin_q[i]   <= (leg_d[i] == LEG_HI);
                lin_n_q[i] <= (leg_d[i] != LEG_LO);
            end
        end
    end

    assign HIN_R  = hin_q[LEG_R];
    assign HIN_S  = hin_q[LEG_S];
    assign HIN_T  = hin_q[LEG_T];
    assign _LIN_R = lin_n_q[LEG_R];
    assign _LIN_S = lin_n_q[LEG_S];
    assign _LIN_T = lin_n_q[LEG_T];

endmodule

// File: tb/tb_bldc_commutation_gate_driver.sv
// tb_bldc_commutation_gate_driver
// Directed, table-driven bench for the commutation stage. Define COMM_BRAKE_EN
// together with the RTL to include the brake sequence.

module tb_bldc_commutation_gate_driver;

    localparam int PWM_W       = 8;
    localparam int DEAD_CYCLES = 8;
    localparam int NUM_VECS    = 13;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic [2:0]       rotate_state;
    logic [PWM_W-1:0] duty_level;
`ifdef COMM_BRAKE_EN
    logic             brake;
`endif
    logic             duty;
    logic             HIN_R;
    logic             HIN_S;
    logic             HIN_T;
    logic             _LIN_R;
    logic             _LIN_S;
    logic             _LIN_T;
    logic             state_fault;

    logic [2:0]       hin;
    logic [2:0]       lin_n;

    int vectors       = 0;
    int miscompares   = 0;
    int overlap_count = 0;

    typedef struct packed {
        logic        en;
        logic [2:0]  rs;
        logic [7:0]  dl;
        logic [15:0] cycles;
        logic [2:0]  hin;
        logic [2:0]  lin_n;
        logic        duty;
        logic        fault;
    } vec_t;

    vec_t vecs [NUM_VECS];

    bldc_commutation_gate_driver #(
        .PWM_W       (PWM_W),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rotate_state (rotate_state),
        .duty_level   (duty_level),
`ifdef COMM_BRAKE_EN
        .brake        (brake),
`endif
        .duty         (duty),
        .HIN_R        (HIN_R),
        .HIN_S        (HIN_S),
        .HIN_T        (HIN_T),
        ._LIN_R       (_LIN_R),
        ._LIN_S       (_LIN_S),
        ._LIN_T       (_LIN_T),
        .state_fault  (state_fault)
    );

    assign hin   = {HIN_T, HIN_S, HIN_R};
    assign lin_n = {_LIN_T, _LIN_S, _LIN_R};

    always #5 clk = ~clk;

    // Shoot-through watch: a high side and its low side on together is never acceptable.
    always @(negedge clk) begin
        if ((hin & ~lin_n) != 3'b000) begin
            overlap_count++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] rs, input logic [7:0] dl, input int cycles);
        enable       = en;
        rotate_state = rs;
        duty_level   = dl;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int   hi_count;
        int   lin_s_count;
        int   t_off_count;
        int   match_count;
        int   run;
        int   hin_r_fall;
        int   lin_r_fall;
        int   hin_s_rise;
        logic prev;
        logic found;

        //              en    rs    dl      cyc     hin     lin_n   duty  fault
        vecs[0]  = '{1'b1, 3'd0, 8'd255, 16'd12,  3'b001, 3'b101, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 8'd255, 16'd12,  3'b001, 3'b011, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 8'd255, 16'd12,  3'b010, 3'b011, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 3'd3, 8'd255, 16'd12,  3'b010, 3'b110, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 3'd4, 8'd255, 16'd12,  3'b100, 3'b110, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 3'd5, 8'd255, 16'd12,  3'b100, 3'b101, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 8'd255, 16'd12,  3'b001, 3'b101, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 3'd0, 8'd255, 16'd1,   3'b000, 3'b111, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'd0, 8'd255, 16'd12,  3'b001, 3'b101, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 3'd0, 8'd0,   16'd300, 3'b000, 3'b101, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 3'd7, 8'd0,   16'd3,   3'b000, 3'b111, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 3'd2, 8'd0,   16'd12,  3'b000, 3'b011, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 3'd6, 8'd0,   16'd3,   3'b000, 3'b111, 1'b0, 1'b1};

        // Reset held with the clock running
        rst_n        = 1'b0;
        enable       = 1'b0;
        rotate_state = 3'd0;
        duty_level   = '0;
`ifdef COMM_BRAKE_EN
        brake        = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset_hin", hin, 3'b000);
        checkOutput("reset_lin_n", lin_n, 3'b111);
        checkOutput("reset_duty", duty, 1'b0);
        checkOutput("reset_fault", state_fault, 1'b0);
        rst_n = 1'b1;

        // Table sweep: all six steps, enable, duty extremes and invalid steps
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].en, vecs[i].rs, vecs[i].dl, int'(vecs[i].cycles));
            checkOutput($sformatf("vec%0d_hin", i), hin, vecs[i].hin);
            checkOutput($sformatf("vec%0d_lin_n", i), lin_n, vecs[i].lin_n);
            checkOutput($sformatf("vec%0d_duty", i), duty, vecs[i].duty);
            checkOutput($sformatf("vec%0d_fault", i), state_fault, vecs[i].fault);
        end

        // Only reset clears the sticky fault
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rereset_fault", state_fault, 1'b0);
        checkOutput("rereset_hin", hin, 3'b000);
        checkOutput("rereset_lin_n", lin_n, 3'b111);
        rst_n = 1'b1;

        // PWM at duty 64 in step 0
        applyStimulus(1'b1, 3'd0, 8'd64, 300);
        hi_count    = 0;
        lin_s_count = 0;
        t_off_count = 0;
        match_count = 0;
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            if (HIN_R) hi_count++;
            if (!_LIN_S) lin_s_count++;
            if (!HIN_T && _LIN_T) t_off_count++;
            if (HIN_R == duty) match_count++;
        end
        checkOutput("pwm64_hin_r_on", hi_count, 64);
        checkOutput("pwm64_lin_s_on", lin_s_count, 255);
        checkOutput("pwm64_t_off", t_off_count, 255);
        checkOutput("pwm64_duty_tracks", match_count, 255);

        // Mid-period duty change waits for the next period start
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            prev = HIN_R;
            @(negedge clk);
            if (!prev && HIN_R) found = 1'b1;
        end
        checkOutput("pwm_rise_1", found, 1'b1);
        repeat (100) @(negedge clk);
        duty_level = 8'd128;
        hi_count   = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (HIN_R) hi_count++;
        end
        checkOutput("duty_hold_mid_period", hi_count, 0);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            prev = HIN_R;
            @(negedge clk);
            if (!prev && HIN_R) found = 1'b1;
        end
        checkOutput("pwm_rise_2", found, 1'b1);
        run = 0;
        while (HIN_R === 1'b1 && run < 400) begin
            run++;
            @(negedge clk);
        end
        checkOutput("duty128_run", run, 128);

        // Full duty: no gaps inside the step
        duty_level = 8'd255;
        repeat (300) @(negedge clk);
        hi_count = 0;
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            if (HIN_R) hi_count++;
        end
        checkOutput("duty255_no_gap", hi_count, 255);

        // Step 0 -> 3: R swaps HI to LO and S swaps LO to HI through the dead time
        rotate_state = 3'd3;
        hin_r_fall   = 0;
        lin_r_fall   = 0;
        hin_s_rise   = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (hin_r_fall == 0 && !HIN_R) hin_r_fall = k;
            if (lin_r_fall == 0 && !_LIN_R) lin_r_fall = k;
            if (hin_s_rise == 0 && HIN_S) hin_s_rise = k;
        end
        checkOutput("dead_hin_r_off", hin_r_fall, 2);
        checkOutput("dead_lin_r_on", lin_r_fall, 2 + DEAD_CYCLES);
        checkOutput("dead_hin_s_on", hin_s_rise, 2 + DEAD_CYCLES);
        checkOutput("dead_gap_min", (lin_r_fall - hin_r_fall) >= DEAD_CYCLES, 1'b1);

        // Asynchronous reset drops the gates between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_hin_s", HIN_S, 1'b0);
        checkOutput("async_lin_r", _LIN_R, 1'b1);
        checkOutput("async_duty", duty, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef COMM_BRAKE_EN
        // Brake during step 1: all low sides on, R only after the dead time
        applyStimulus(1'b1, 3'd1, 8'd255, 20);
        checkOutput("brake_pre_hin_r", HIN_R, 1'b1);
        checkOutput("brake_pre_lin_t", _LIN_T, 1'b0);
        brake      = 1'b1;
        hin_r_fall = 0;
        lin_r_fall = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (hin_r_fall == 0 && !HIN_R) hin_r_fall = k;
            if (lin_r_fall == 0 && !_LIN_R) lin_r_fall = k;
        end
        checkOutput("brake_hin_r_off", hin_r_fall, 1);
        checkOutput("brake_lin_r_on", lin_r_fall, 1 + DEAD_CYCLES);
        checkOutput("brake_hin", hin, 3'b000);
        checkOutput("brake_lin_n", lin_n, 3'b000);
        checkOutput("brake_duty_runs", duty, 1'b1);
        brake = 1'b0;
`endif

        checkOutput("no_shoot_through", overlap_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
